bus_arbiter_rr: RTL and testbench

- Parametrised successor to the system bus controller.
- Arbitrates the shared system bus among N masters: I-cache, D-cache, DMA engines.
- Fixed-priority or round-robin selection, chosen by parameter.
- Grant is held for the whole multi-word transfer, e.g. a cache line fill.
- One dead turn-around cycle between owners; a watchdog aborts a grant when the slave stops answering.
- Sits between the masters' DMA request lines and the slave's BUS_ready handshake.

---
 rtl/bus_arbiter_rr_pkg.sv | 26 ++
 rtl/bus_arbiter_rr_pick.sv | 36 +++
 rtl/bus_arbiter_rr.sv | 131 +++++++++++++
 tb/tb_bus_arbiter_rr.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_arbiter_rr_pkg.sv
// Shared definitions for the system bus arbiter: state encoding, default sizing
// and the one-hot helper used to form grant vectors.
package bus_arbiter_rr_pkg;

  localparam int DEFAULT_N       = 8;
  localparam int DEFAULT_TIMEOUT = 64;
  localparam int DEFAULT_IDW     = 3;

  localparam int MAX_N   = 16;
  localparam int MAX_IDW = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_TURN  = 2'd2
  } bus_state_e;

  // Widest one-hot vector; callers cast it down to their own master count.
  function automatic logic [MAX_N-1:0] onehot(input logic [MAX_IDW-1:0] idx);
    logic [MAX_N-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// Find-first-set over the request vector, starting at ptr and wrapping from
// N-1 back to 0. With ptr tied to zero it degenerates to lowest-index-wins.
module bus_arbiter_rr_pick
  import bus_arbiter_rr_pkg::*;
#(
  parameter int N   = DEFAULT_N,
  parameter int IDW = DEFAULT_IDW
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic           valid,
  output logic [IDW-1:0] idx
);

  localparam logic [IDW:0] N_W = (IDW + 1)'(N);

  logic [IDW:0] pos;

  // NOTE: every variable driven here gets a default before any branch, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    pos   = '0;
    // Walk from the farthest offset down so the nearest hit to ptr wins.
    for (int k = N - 1; k >= 0; k--) begin
      pos = {1'b0, ptr} + (IDW + 1)'(k);
      if (pos >= N_W) pos = pos - N_W;
      if (req[pos[IDW-1:0]]) begin
        valid = 1'b1;
        idx   = pos[IDW-1:0];
      end
    end
  end

endmodule

// File: rtl/bus_arbiter_rr.sv
// System bus arbiter: one grant held for a whole transfer, a dead turn-around
// cycle between owners, and a watchdog that aborts a grant on a silent slave.
module bus_arbiter_rr
  import bus_arbiter_rr_pkg::*;
#(
  parameter int N       = DEFAULT_N,
  parameter int RR_MODE = 1,
  parameter int TIMEOUT = DEFAULT_TIMEOUT,
  parameter int IDW     = DEFAULT_IDW
) (
  input  logic           clk,
  input  logic           clr,
  input  logic [N-1:0]   DMA,
  input  logic           BUS_ready,
  output logic [N-1:0]   grant,
  output logic           BUS_req,
  output logic [IDW-1:0] owner,
  output logic           bus_busy,
  output logic           bus_err
);

  localparam int              CW       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0]   WD_LAST  = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
  localparam logic [IDW-1:0]  LAST_IDX = IDW'(N - 1);

  bus_state_e     state_q, state_d;
  logic [N-1:0]   grant_q, grant_d;
  logic [IDW-1:0] owner_q, owner_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [CW-1:0]  wd_q, wd_d;
  logic           busy_q, busy_d;
  logic           err_q, err_d;

  logic [IDW-1:0] pick_ptr;
  logic           pick_valid;
  logic [IDW-1:0] pick_idx;
  logic           owner_req;
  logic           wd_expire;
  logic [IDW-1:0] ptr_next;

  // Fixed priority is the same search anchored permanently at master 0.
  assign pick_ptr = (RR_MODE != 0) ? ptr_q : '0;

  bus_arbiter_rr_pick #(
    .N   (N),
    .IDW (IDW)
  ) u_rr_pick (
    .req   (DMA),
    .ptr   (pick_ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  assign owner_req = DMA[owner_q];
  assign wd_expire = (TIMEOUT > 0) && !BUS_ready && (wd_q == WD_LAST);
  assign ptr_next  = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    wd_d    = wd_q;
    err_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          state_d = ST_GRANT;
          grant_d = N'(onehot(MAX_IDW'(pick_idx)));
          owner_d = pick_idx;
          wd_d    = '0;
        end
      end

      ST_GRANT: begin
        // An abort coinciding with the owner's release is still one abort.
        if (wd_expire || !owner_req) begin
          state_d = ST_TURN;
          grant_d = '0;
          ptr_d   = ptr_next;
          err_d   = wd_expire;
        end else if (BUS_ready) begin
          wd_d = '0;
        end else begin
          wd_d = (TIMEOUT > 0) ? wd_q + 1'b1 : '0;
        end
      end

      ST_TURN: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
      wd_q    <= '0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      wd_q    <= wd_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  assign grant    = grant_q;
  assign BUS_req  = |grant_q;
  assign owner    = owner_q;
  assign bus_busy = busy_q;
  assign bus_err  = err_q;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Bench for bus_arbiter_rr: a round-robin/watchdog instance and a fixed-priority
// instance share stimulus and are compared every cycle against a behavioural model.
module tb_bus_arbiter_rr;

  localparam int NA = 8;
  localparam int TA = 8;
  localparam int NB = 4;
  localparam int TB = 0;

  logic       clk = 1'b0;
  logic       clr;
  logic [7:0] dma;
  logic       rdy;

  logic [NA-1:0] grant_a;
  logic          req_a;
  logic [2:0]    owner_a;
  logic          busy_a;
  logic          err_a;

  logic [NB-1:0] grant_b;
  logic          req_b;
  logic [1:0]    owner_b;
  logic          busy_b;
  logic          err_b;

  always #5 clk = ~clk;

  bus_arbiter_rr #(.N(NA), .RR_MODE(1), .TIMEOUT(TA), .IDW(3)) dut_a (
    .clk       (clk),
    .clr       (clr),
    .DMA       (dma),
    .BUS_ready (rdy),
    .grant     (grant_a),
    .BUS_req   (req_a),
    .owner     (owner_a),
    .bus_busy  (busy_a),
    .bus_err   (err_a)
  );

  bus_arbiter_rr #(.N(NB), .RR_MODE(0), .TIMEOUT(TB), .IDW(2)) dut_b (
    .clk       (clk),
    .clr       (clr),
    .DMA       (dma[3:0]),
    .BUS_ready (rdy),
    .grant     (grant_b),
    .BUS_req   (req_b),
    .owner     (owner_b),
    .bus_busy  (busy_b),
    .bus_err   (err_b)
  );

  // Model: who holds the bus, whether the bus is cooling down, where the
  // round-robin search starts, and how long the slave has been silent.
  typedef struct {
    bit owned;
    bit cool;
    bit err;
    int who;
    int ptr;
    int silent;
  } mdl_t;

  mdl_t ma, mb;
  int   checks   = 0;
  int   failures = 0;
  bit   cmp_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(inout mdl_t m, input int n, input int rr, input int tmo,
                      input logic [15:0] req, input logic rd, input logic rst);
    bit found;
    if (rst) begin
      m.owned = 0; m.cool = 0; m.err = 0; m.who = 0; m.ptr = 0; m.silent = 0;
      return;
    end
    m.err = 0;
    if (m.owned) begin
      if (tmo > 0 && !rd && m.silent + 1 >= tmo) begin
        m.owned = 0; m.cool = 1; m.err = 1; m.ptr = (m.who + 1) % n;
      end else if (((req >> m.who) & 16'd1) == 16'd0) begin
        m.owned = 0; m.cool = 1; m.ptr = (m.who + 1) % n;
      end else begin
        m.silent = rd ? 0 : m.silent + 1;
      end
    end else if (m.cool) begin
      m.cool = 0;
    end else begin
      found = 0;
      for (int k = 0; k < n; k++) begin
        int c;
        c = (rr != 0) ? (m.ptr + k) % n : k;
        if (!found && ((req >> c) & 16'd1) != 16'd0) begin
          found = 1; m.owned = 1; m.who = c; m.silent = 0;
        end
      end
    end
  endtask

  task automatic cmp_dut(input string tag, input mdl_t m, input logic [31:0] g,
                         input logic [31:0] o, input logic [31:0] rq,
                         input logic [31:0] bz, input logic [31:0] er);
    logic [31:0] eg;
    eg = m.owned ? (32'd1 << m.who) : 32'd0;
    check({tag, "_grant"}, g, eg);
    check({tag, "_owner"}, o, 32'(m.who));
    check({tag, "_bus_req"}, rq, 32'(m.owned));
    check({tag, "_busy"}, bz, 32'(m.owned | m.cool));
    check({tag, "_err"}, er, 32'(m.err));
  endtask

  initial begin
    forever begin
      @(posedge clk);
      step(ma, NA, 1, TA, {8'h00, dma}, rdy, clr);
      step(mb, NB, 0, TB, {12'h000, dma[3:0]}, rdy, clr);
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        cmp_dut("a", ma, 32'(grant_a), 32'(owner_a), 32'(req_a), 32'(busy_a), 32'(err_a));
        cmp_dut("b", mb, 32'(grant_b), 32'(owner_b), 32'(req_b), 32'(busy_b), 32'(err_b));
      end
    end
  end

  logic [7:0] rr_grant [5];
  logic [2:0] rr_owner [5];

  initial begin
    rr_grant = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h01};
    rr_owner = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0};
    clr = 1'b1;
    dma = 8'hFF;
    rdy = 1'b0;

    // Reset held with every master requesting.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      cmp_en = 1'b1;
      check("rst_grant", 32'(grant_a), 32'h0);
      check("rst_bus_req", 32'(req_a), 32'h0);
      check("rst_owner", 32'(owner_a), 32'h0);
    end
    clr = 1'b0;
    @(negedge clk);
    check("first_grant_a", 32'(grant_a), 32'h01);
    check("first_grant_b", 32'(grant_b), 32'h1);
    dma = 8'h00;
    @(negedge clk);
    check("turn_grant", 32'(grant_a), 32'h0);
    check("turn_busy", 32'(busy_a), 32'h1);
    @(negedge clk);

    // Long hold with ready pulses; master 0 joins mid-transfer.
    dma = 8'h02;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold_grant", 32'(grant_a), 32'h02);
      rdy = (i < 8) && (i % 2 == 0);
      if (i == 2) dma = dma | 8'h01;
    end
    dma = 8'h01;
    rdy = 1'b0;
    @(negedge clk);
    check("hold_turn_grant", 32'(grant_a), 32'h0);
    check("hold_turn_busy", 32'(busy_a), 32'h1);
    check("hold_turn_owner", 32'(owner_a), 32'h1);
    @(negedge clk);
    check("hold_idle_busy", 32'(busy_a), 32'h0);
    @(negedge clk);
    check("next_owner_grant", 32'(grant_a), 32'h01);
    dma = 8'h00;
    repeat (2) @(negedge clk);

    // Reset in the middle of a transfer, then round-robin from pointer 0.
    dma = 8'h10;
    @(negedge clk);
    check("mid_grant", 32'(grant_a), 32'h10);
    check("mid_owner", 32'(owner_a), 32'h4);
    clr = 1'b1;
    dma = 8'h0F;
    @(negedge clk);
    check("mid_rst_grant", 32'(grant_a), 32'h0);
    check("mid_rst_owner", 32'(owner_a), 32'h0);
    check("mid_rst_busy", 32'(busy_a), 32'h0);
    clr = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("rr_grant", 32'(grant_a), 32'(rr_grant[k]));
      check("rr_owner", 32'(owner_a), 32'(rr_owner[k]));
      @(negedge clk);
      dma = 8'h0F & ~rr_grant[k];
      @(negedge clk);
      dma = 8'h0F;
      @(negedge clk);
    end
    dma = 8'h00;
    repeat (4) @(negedge clk);

    // Fixed priority versus round-robin on the same requests.
    dma = 8'h0C;
    @(negedge clk);
    check("fp_first_b", 32'(grant_b), 32'h4);
    check("fp_first_a", 32'(grant_a), 32'h04);
    dma = 8'h08;
    @(negedge clk);
    dma = 8'h0E;
    repeat (2) @(negedge clk);
    check("fp_second_b", 32'(grant_b), 32'h2);
    check("fp_second_a", 32'(grant_a), 32'h08);
    dma = 8'h00;
    repeat (4) @(negedge clk);

    // Watchdog: silent slave, abort, re-grant, then a ready restarts the count.
    rdy = 1'b0;
    dma = 8'h02;
    @(negedge clk);
    check("wd_grant", 32'(grant_a), 32'h02);
    for (int j = 1; j <= 8; j++) begin
      @(negedge clk);
      check("wd_err", 32'(err_a), (j == 8) ? 32'h1 : 32'h0);
      check("wd_hold", 32'(grant_a), (j == 8) ? 32'h0 : 32'h02);
    end
    @(negedge clk);
    check("wd_err_pulse", 32'(err_a), 32'h0);
    check("wd_gap_grant", 32'(grant_a), 32'h0);
    @(negedge clk);
    check("wd_regrant", 32'(grant_a), 32'h02);
    for (int j = 1; j <= 12; j++) begin
      @(negedge clk);
      check("wd2_err", 32'(err_a), (j == 12) ? 32'h1 : 32'h0);
      check("wd2_hold", 32'(grant_a), (j == 12) ? 32'h0 : 32'h02);
      if (j == 3) rdy = 1'b1;
      if (j == 4) rdy = 1'b0;
    end
    dma = 8'h00;
    repeat (4) @(negedge clk);

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int b = 0; b < 8; b++) begin
        if ($urandom_range(7) == 0) dma = dma ^ (8'h01 << b);
      end
      rdy = ($urandom_range(3) == 0);
      clr = ($urandom_range(199) == 0);
    end
    clr = 1'b0;
    dma = 8'h00;
    rdy = 1'b0;
    repeat (5) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
